// File: rtl/stabilizer_tableau_array.sv
// ============================================================================
// stabilizer_tableau_array : NUM_QUBIT x NUM_QUBIT Pauli tableau with
// rotation tracking, hardware realign and gate-info latch.
// Optional macro TABLEAU_ROW_SWAP_EN enables SWAP_BOT. Revision 1.0
// ============================================================================
`default_nettype none

module stabilizer_tableau_array #(
   parameter  int NUM_QUBIT = 4,
   parameter  int LIT_W     = 2,
   parameter  int POS_W     = 32,
   localparam int OFS_W     = $clog2(NUM_QUBIT),
   localparam int ROW_W     = NUM_QUBIT * LIT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd_op,
   output logic             cmd_ready,
   input  logic [ROW_W-1:0] literals_in,
   input  logic             phase_in,
   output logic [ROW_W-1:0] literals_out,
   output logic             phase_out,
   output logic [OFS_W-1:0] row_offset,
   output logic [OFS_W-1:0] col_offset,
   output logic [OFS_W:0]   fill_count,
   output logic             realign_done,
   output logic             cmd_err,
   input  logic             ld_gate_info,
   input  logic [1:0]       gate_type,
   input  logic [POS_W-1:0] qubit_pos,
   input  logic [POS_W-1:0] qubit_pos2,
   output logic [1:0]       reg_gate_type,
   output logic [POS_W-1:0] reg_qubit_pos,
   output logic [POS_W-1:0] reg_qubit_pos2
);

   localparam int               TAB_W    = NUM_QUBIT * ROW_W;
   localparam logic [OFS_W-1:0] HALF     = OFS_W'(NUM_QUBIT / 2);
   localparam logic [OFS_W-1:0] OFS_MAX  = OFS_W'(NUM_QUBIT - 1);
   localparam logic [OFS_W:0]   FILL_MAX = (OFS_W + 1)'(NUM_QUBIT);

   localparam logic [2:0] OP_SHIFT_IN  = 3'd0;
   localparam logic [2:0] OP_ROT_DOWN  = 3'd1;
   localparam logic [2:0] OP_ROT_LEFT  = 3'd2;
   localparam logic [2:0] OP_ROT_UP    = 3'd3;
   localparam logic [2:0] OP_ROT_RIGHT = 3'd4;
   localparam logic [2:0] OP_SWAP_BOT  = 3'd5;
   localparam logic [2:0] OP_REALIGN   = 3'd6;
   localparam logic [2:0] OP_CLEAR     = 3'd7;

   typedef enum logic [1:0] {IDLE, RE_ROW, RE_COL, DONE} state_t;
   typedef enum logic [2:0] {ACT_NONE, ACT_SHIFT, ACT_DOWN, ACT_UP,
                             ACT_LEFT, ACT_RIGHT, ACT_SWAP, ACT_CLEAR} act_t;

   // Row r occupies tab_q[r*ROW_W +: ROW_W]; row NUM_QUBIT-1 is the bottom.
   logic [TAB_W-1:0]     tab_q, tab_d;
   logic [NUM_QUBIT-1:0] ph_q, ph_d;
   logic [OFS_W-1:0]     row_ofs_q, row_ofs_d, col_ofs_q, col_ofs_d;
   logic [OFS_W:0]       fill_q, fill_d;
   logic                 err_q, err_d;
   state_t               state_q, state_d;
   act_t                 act;
   logic [1:0]           gtype_q, gtype_d;
   logic [POS_W-1:0]     gpos_q, gpos_d, gpos2_q, gpos2_d;
   logic [TAB_W-1:0]     tab_left, tab_right;

   function automatic logic [OFS_W-1:0] ofs_inc(input logic [OFS_W-1:0] v);
      return (v == OFS_MAX) ? '0 : v + 1'b1;
   endfunction

   function automatic logic [OFS_W-1:0] ofs_dec(input logic [OFS_W-1:0] v);
      return (v == '0) ? OFS_MAX : v - 1'b1;
   endfunction

   for (genvar r = 0; r < NUM_QUBIT; r++) begin : g_row
      assign tab_left[r*ROW_W +: ROW_W]  = {tab_q[r*ROW_W +: LIT_W],
                                            tab_q[r*ROW_W+LIT_W +: ROW_W-LIT_W]};
      assign tab_right[r*ROW_W +: ROW_W] = {tab_q[r*ROW_W +: ROW_W-LIT_W],
                                            tab_q[r*ROW_W+ROW_W-LIT_W +: LIT_W]};
   end

`ifdef TABLEAU_ROW_SWAP_EN
   logic [TAB_W-1:0]     tab_swap;
   logic [NUM_QUBIT-1:0] ph_swap;
   if (NUM_QUBIT == 2) begin : g_swap2
      assign tab_swap = {tab_q[ROW_W-1:0], tab_q[TAB_W-1 -: ROW_W]};
      assign ph_swap  = {ph_q[0], ph_q[1]};
   end else begin : g_swapn
      assign tab_swap = {tab_q[(NUM_QUBIT-2)*ROW_W +: ROW_W],
                         tab_q[(NUM_QUBIT-1)*ROW_W +: ROW_W],
                         tab_q[(NUM_QUBIT-2)*ROW_W-1:0]};
      assign ph_swap  = {ph_q[NUM_QUBIT-2], ph_q[NUM_QUBIT-1], ph_q[NUM_QUBIT-3:0]};
   end
`endif

   // Command decode and realign sequencing; realign takes the shortest way home.
   always_comb begin
      state_d = state_q;
      act     = ACT_NONE;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_SHIFT_IN:  act = ACT_SHIFT;
                  OP_ROT_DOWN:  act = ACT_DOWN;
                  OP_ROT_LEFT:  act = ACT_LEFT;
                  OP_ROT_UP:    act = ACT_UP;
                  OP_ROT_RIGHT: act = ACT_RIGHT;
`ifdef TABLEAU_ROW_SWAP_EN
                  OP_SWAP_BOT:  act = ACT_SWAP;
`else
                  OP_SWAP_BOT:  err_d = 1'b1;
`endif
                  OP_REALIGN:   state_d = RE_ROW;
                  OP_CLEAR:     act = ACT_CLEAR;
                  default:      act = ACT_NONE;
               endcase
            end
         end
         RE_ROW: begin
            if (row_ofs_q != '0) act = (row_ofs_q <= HALF) ? ACT_UP : ACT_DOWN;
            else                 state_d = RE_COL;
         end
         RE_COL: begin
            if (col_ofs_q != '0) act = (col_ofs_q <= HALF) ? ACT_RIGHT : ACT_LEFT;
            else                 state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tab_d     = tab_q;
      ph_d      = ph_q;
      row_ofs_d = row_ofs_q;
      col_ofs_d = col_ofs_q;
      fill_d    = fill_q;
      case (act)
         ACT_SHIFT: begin
            tab_d  = {tab_q[TAB_W-ROW_W-1:0], literals_in};
            ph_d   = {ph_q[NUM_QUBIT-2:0], phase_in};
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
         end
         ACT_DOWN: begin
            tab_d     = {tab_q[TAB_W-ROW_W-1:0], tab_q[TAB_W-1 -: ROW_W]};
            ph_d      = {ph_q[NUM_QUBIT-2:0], ph_q[NUM_QUBIT-1]};
            row_ofs_d = ofs_inc(row_ofs_q);
         end
         ACT_UP: begin
            tab_d     = {tab_q[ROW_W-1:0], tab_q[TAB_W-1:ROW_W]};
            ph_d      = {ph_q[0], ph_q[NUM_QUBIT-1:1]};
            row_ofs_d = ofs_dec(row_ofs_q);
         end
         ACT_LEFT: begin
            tab_d     = tab_left;
            col_ofs_d = ofs_inc(col_ofs_q);
         end
         ACT_RIGHT: begin
            tab_d     = tab_right;
            col_ofs_d = ofs_dec(col_ofs_q);
         end
`ifdef TABLEAU_ROW_SWAP_EN
         ACT_SWAP: begin
            tab_d = tab_swap;
            ph_d  = ph_swap;
         end
`endif
         ACT_CLEAR: begin
            tab_d     = '0;
            ph_d      = '0;
            row_ofs_d = '0;
            col_ofs_d = '0;
            fill_d    = '0;
         end
         default: tab_d = tab_q;
      endcase
   end

   always_comb begin
      gtype_d = gtype_q;
      gpos_d  = gpos_q;
      gpos2_d = gpos2_q;
      if (ld_gate_info) begin
         gtype_d = gate_type;
         gpos_d  = qubit_pos;
         gpos2_d = qubit_pos2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tab_q     <= '0;
         ph_q      <= '0;
         row_ofs_q <= '0;
         col_ofs_q <= '0;
         fill_q    <= '0;
         err_q     <= 1'b0;
         gtype_q   <= '0;
         gpos_q    <= '0;
         gpos2_q   <= '0;
      end else begin
         state_q   <= state_d;
         tab_q     <= tab_d;
         ph_q      <= ph_d;
         row_ofs_q <= row_ofs_d;
         col_ofs_q <= col_ofs_d;
         fill_q    <= fill_d;
         err_q     <= err_d;
         gtype_q   <= gtype_d;
         gpos_q    <= gpos_d;
         gpos2_q   <= gpos2_d;
      end
   end

   assign cmd_ready      = (state_q == IDLE);
   assign realign_done   = (state_q == DONE);
   assign cmd_err        = err_q;
   assign literals_out   = tab_q[TAB_W-1 -: ROW_W];
   assign phase_out      = ph_q[NUM_QUBIT-1];
   assign row_offset     = row_ofs_q;
   assign col_offset     = col_ofs_q;
   assign fill_count     = fill_q;
   assign reg_gate_type  = gtype_q;
   assign reg_qubit_pos  = gpos_q;
   assign reg_qubit_pos2 = gpos2_q;

endmodule

`default_nettype wire

// File: tb/tb_stabilizer_tableau_array.sv
// ============================================================================
// tb_stabilizer_tableau_array : directed + random checks against an
// array-based tableau model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_stabilizer_tableau_array;
   localparam int N  = 4;
   localparam int LW = 2;
   localparam int PW = 32;
   localparam int OW = $clog2(N);
   localparam int RW = N * LW;

   localparam logic [RW-1:0] ROW_A = 8'h1B;
   localparam logic [RW-1:0] ROW_B = 8'hE4;
   localparam logic [RW-1:0] ROW_C = 8'h93;
   localparam logic [RW-1:0] ROW_D = 8'h6C;
   localparam logic [RW-1:0] ROW_E = 8'h5A;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic [2:0]    cmd_op;
   logic          cmd_ready;
   logic [RW-1:0] literals_in;
   logic          phase_in;
   logic [RW-1:0] literals_out;
   logic          phase_out;
   logic [OW-1:0] row_offset, col_offset;
   logic [OW:0]   fill_count;
   logic          realign_done, cmd_err;
   logic          ld_gate_info;
   logic [1:0]    gate_type, reg_gate_type;
   logic [PW-1:0] qubit_pos, qubit_pos2, reg_qubit_pos, reg_qubit_pos2;

   stabilizer_tableau_array #(.NUM_QUBIT(N), .LIT_W(LW), .POS_W(PW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .literals_in(literals_in), .phase_in(phase_in),
      .literals_out(literals_out), .phase_out(phase_out),
      .row_offset(row_offset), .col_offset(col_offset), .fill_count(fill_count),
      .realign_done(realign_done), .cmd_err(cmd_err),
      .ld_gate_info(ld_gate_info), .gate_type(gate_type),
      .qubit_pos(qubit_pos), .qubit_pos2(qubit_pos2),
      .reg_gate_type(reg_gate_type), .reg_qubit_pos(reg_qubit_pos),
      .reg_qubit_pos2(reg_qubit_pos2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: m_tab[row][col], row N-1 is the bottom.
   logic [LW-1:0] m_tab [N][N];
   logic          m_ph  [N];
   int            m_row, m_col, m_fill;
   logic [1:0]    m_gt;
   logic [PW-1:0] m_p1, m_p2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] pack_row(input int r);
      logic [RW-1:0] v;
      for (int j = 0; j < N; j++) v[j*LW +: LW] = m_tab[r][j];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_ph[i] = 1'b0;
         for (int j = 0; j < N; j++) m_tab[i][j] = '0;
      end
      m_row = 0; m_col = 0; m_fill = 0;
   endtask

   // new row i = old row (i-d) mod N : d=+1 is downward, d=-1 upward
   task automatic m_rows(input int d);
      logic [LW-1:0] t [N][N];
      logic          p [N];
      for (int i = 0; i < N; i++) begin
         p[i] = m_ph[(i - d + N) % N];
         for (int j = 0; j < N; j++) t[i][j] = m_tab[(i - d + N) % N][j];
      end
      m_tab = t;
      m_ph  = p;
   endtask

   // new col j = old col (j+d) mod N : d=+1 is leftward, d=-1 rightward
   task automatic m_cols(input int d);
      logic [LW-1:0] t [N][N];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) t[i][j] = m_tab[i][(j + d + N) % N];
      m_tab = t;
   endtask

   task automatic m_apply(input logic [2:0] op, input logic [RW-1:0] lits,
                          input logic ph, output logic e);
      logic [LW-1:0] tl;
      logic          tp;
      e = 1'b0;
      case (op)
         3'd0: begin
            m_rows(1);
            for (int j = 0; j < N; j++) m_tab[0][j] = lits[j*LW +: LW];
            m_ph[0] = ph;
            m_fill  = (m_fill < N) ? m_fill + 1 : N;
         end
         3'd1: begin m_rows(1);  m_row = (m_row + 1) % N;     end
         3'd2: begin m_cols(1);  m_col = (m_col + 1) % N;     end
         3'd3: begin m_rows(-1); m_row = (m_row + N - 1) % N; end
         3'd4: begin m_cols(-1); m_col = (m_col + N - 1) % N; end
         3'd5: begin
`ifdef TABLEAU_ROW_SWAP_EN
            for (int j = 0; j < N; j++) begin
               tl = m_tab[N-1][j]; m_tab[N-1][j] = m_tab[N-2][j]; m_tab[N-2][j] = tl;
            end
            tp = m_ph[N-1]; m_ph[N-1] = m_ph[N-2]; m_ph[N-2] = tp;
`else
            e = 1'b1;
`endif
         end
         3'd7: m_reset();
         default: e = 1'b0;
      endcase
   endtask

   task automatic drive_gate();
      ld_gate_info = 1'($urandom_range(0, 1));
      gate_type    = 2'($urandom_range(0, 3));
      qubit_pos    = $urandom();
      qubit_pos2   = $urandom();
   endtask

   task automatic step();
      @(posedge clk);
      if (ld_gate_info) begin
         m_gt = gate_type; m_p1 = qubit_pos; m_p2 = qubit_pos2;
      end
      #1;
   endtask

   task automatic check_state(input string tag, input logic exp_err);
      chk({tag, "/lits"},  literals_out, pack_row(N-1));
      chk({tag, "/phase"}, phase_out, m_ph[N-1]);
      chk({tag, "/rowof"}, row_offset, m_row);
      chk({tag, "/colof"}, col_offset, m_col);
      chk({tag, "/fill"},  fill_count, m_fill);
      chk({tag, "/ready"}, cmd_ready, 1'b1);
      chk({tag, "/done"},  realign_done, 1'b0);
      chk({tag, "/err"},   cmd_err, exp_err);
      chk({tag, "/gtype"}, reg_gate_type, m_gt);
      chk({tag, "/gpos"},  reg_qubit_pos, m_p1);
      chk({tag, "/gpos2"}, reg_qubit_pos2, m_p2);
   endtask

   task automatic issue(input logic [2:0] op, input logic [RW-1:0] lits, input logic ph);
      logic e;
      cmd_op = op; literals_in = lits; phase_in = ph; cmd_valid = 1'b1;
      drive_gate();
      step();
      cmd_valid = 1'b0;
      m_apply(op, lits, ph, e);
      check_state($sformatf("op%0d", op), e);
   endtask

   task automatic realign();
      int k, l, n;
      bit seen;
      k = (m_row <= N / 2) ? m_row : N - m_row;
      l = (m_col <= N / 2) ? m_col : N - m_col;
      cmd_op = 3'd6; cmd_valid = 1'b1;
      drive_gate();
      step();
      cmd_op = 3'd7;   // CLEAR offered while busy must be ignored
      n = 0; seen = 0;
      while (!seen && n < 4 * N + 8) begin
         chk("rl_ready", cmd_ready, 1'b0);
         if (realign_done) seen = 1;
         else begin drive_gate(); step(); n++; end
      end
      cmd_valid = 1'b0; ld_gate_info = 1'b0;
      chk("rl_done_seen", seen, 1'b1);
      chk("rl_latency", n, k + l + 2);
      while (m_row != 0)
         if (m_row <= N / 2) begin m_rows(-1); m_row = m_row - 1; end
         else begin m_rows(1); m_row = (m_row + 1) % N; end
      while (m_col != 0)
         if (m_col <= N / 2) begin m_cols(-1); m_col = m_col - 1; end
         else begin m_cols(1); m_col = (m_col + 1) % N; end
      chk("rl_rowof", row_offset, 0);
      chk("rl_colof", col_offset, 0);
      step();
      check_state("post_rl", 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; literals_in = '0; phase_in = 1'b0;
      ld_gate_info = 1'b0; gate_type = '0; qubit_pos = '0; qubit_pos2 = '0;
      m_reset(); m_gt = '0; m_p1 = '0; m_p2 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_state("reset", 1'b0);

      issue(3'd0, ROW_A, 1'b1);
      issue(3'd0, ROW_B, 1'b0);
      issue(3'd0, ROW_C, 1'b1);
      issue(3'd0, ROW_D, 1'b0);
      chk("load_bottom", literals_out, ROW_A);
      chk("load_fill", fill_count, 4);

      repeat (3) issue(3'd1, '0, 1'b0);
      chk("rd3_row", row_offset, 3);
      chk("rd3_bottom", literals_out, ROW_D);
      realign();
      chk("rl1_bottom", literals_out, ROW_A);

      issue(3'd0, ROW_E, 1'b1);
      chk("shiftE_bottom", literals_out, ROW_B);
      chk("shiftE_fill", fill_count, 4);

      repeat (2) issue(3'd2, '0, 1'b0);
      issue(3'd4, '0, 1'b0);
      chk("col_one", col_offset, 1);
      issue(3'd4, '0, 1'b0);
      issue(3'd4, '0, 1'b0);
      chk("col_wrap", col_offset, 3);

      repeat (2) issue(3'd1, '0, 1'b0);
      issue(3'd4, '0, 1'b0);
      chk("pre_rl_row", row_offset, 2);
      chk("pre_rl_col", col_offset, 2);
      realign();
      repeat (N) issue(3'd1, '0, 1'b0);

      issue(3'd7, '0, 1'b0);
      issue(3'd0, ROW_D, 1'b1);
      issue(3'd0, ROW_C, 1'b0);
      issue(3'd0, ROW_B, 1'b1);
      issue(3'd0, ROW_A, 1'b0);
      issue(3'd5, '0, 1'b0);
`ifdef TABLEAU_ROW_SWAP_EN
      chk("swap_bottom", literals_out, ROW_C);
      issue(3'd1, '0, 1'b0);
      chk("swap_row2", literals_out, ROW_D);
`else
      chk("noswap_bottom", literals_out, ROW_D);
      chk("noswap_err", cmd_err, 1'b1);
      issue(3'd1, '0, 1'b0);
`endif

      // Reset asserted while the realign sequencer is in RE_ROW.
      issue(3'd1, '0, 1'b0);
      cmd_op = 3'd6; cmd_valid = 1'b1; ld_gate_info = 1'b0;
      step();
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      m_reset(); m_gt = '0; m_p1 = '0; m_p2 = '0;
      check_state("rst_mid", 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_nodone", realign_done, 1'b0);
      end
      rst = 1'b0;
      repeat (3) begin
         step();
         check_state("rst_after", 1'b0);
      end

      for (int it = 0; it < 80; it++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (op == 3'd6) realign();
         else issue(op, RW'($urandom()), 1'($urandom_range(0, 1)));
      end
      realign();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
